// File: rtl/rmw_sequencer_pkg.sv
// Shared ALU op codes, status flag bit positions and bus widths for the RMW sequencer.
`timescale 1ns/1ps
package rmw_sequencer_pkg;

    localparam int unsigned ADDR_W   = 16;
    localparam int unsigned DATA_W   = 8;
    localparam int unsigned ALU_OP_W = 4;
    localparam int unsigned FLAGS_W  = 7;

    // ALU op codes shared with the ALU and the instruction decoder
    localparam logic [ALU_OP_W-1:0] ALU_ORA = 4'h0;
    localparam logic [ALU_OP_W-1:0] ALU_AND = 4'h1;
    localparam logic [ALU_OP_W-1:0] ALU_EOR = 4'h2;
    localparam logic [ALU_OP_W-1:0] ALU_ADC = 4'h3;
    localparam logic [ALU_OP_W-1:0] ALU_SBC = 4'h4;
    localparam logic [ALU_OP_W-1:0] ALU_CMP = 4'h5;
    localparam logic [ALU_OP_W-1:0] ALU_ASL = 4'h6;
    localparam logic [ALU_OP_W-1:0] ALU_LSR = 4'h7;
    localparam logic [ALU_OP_W-1:0] ALU_ROL = 4'h8;
    localparam logic [ALU_OP_W-1:0] ALU_ROR = 4'h9;
    localparam logic [ALU_OP_W-1:0] ALU_INC = 4'hA;
    localparam logic [ALU_OP_W-1:0] ALU_DEC = 4'hB;
    localparam logic [ALU_OP_W-1:0] ALU_NOP = 4'hF;

    // Status register bit positions applied by the status register
    localparam int unsigned FLAG_C = 0;
    localparam int unsigned FLAG_Z = 1;
    localparam int unsigned FLAG_N = 6;

    function automatic logic is_rmw_op(input logic [ALU_OP_W-1:0] op);
        return (op == ALU_ASL) || (op == ALU_LSR) || (op == ALU_ROL) || (op == ALU_ROR);
    endfunction

endpackage

// File: rtl/rmw_sequencer.sv
// Bus-cycle sequencer for 6502 ASL/LSR/ROL/ROR on memory or accumulator.
// RMW_DUMMY_WRITE_EN: MODIFY writes the old value back (NMOS double write) instead of a dummy read.
`timescale 1ns/1ps
module rmw_sequencer
    import rmw_sequencer_pkg::*;
(
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    input  logic [ALU_OP_W-1:0] op,
    input  logic                acc_mode,
    input  logic [ADDR_W-1:0]   addr,
    input  logic [DATA_W-1:0]   acc_in,
    output logic                busy,
    output logic                done,
    output logic [ADDR_W-1:0]   mem_addr,
    output logic                mem_rw,
    output logic [DATA_W-1:0]   mem_dout,
    input  logic [DATA_W-1:0]   mem_din,
    output logic [ALU_OP_W-1:0] alu_op,
    output logic [DATA_W-1:0]   alu_a,
    input  logic [DATA_W-1:0]   alu_result,
    input  logic [FLAGS_W-1:0]  alu_flags,
    output logic                acc_we,
    output logic [DATA_W-1:0]   acc_out,
    output logic                flags_we,
    output logic [FLAGS_W-1:0]  flags_out
);

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_READ   = 3'd1,
        ST_MODIFY = 3'd2,
        ST_WRITE  = 3'd3,
        ST_WB_ACC = 3'd4
    } state_t;

    state_t                state;
    logic [ALU_OP_W-1:0]   op_q;
    logic                  acc_mode_q;
    logic [DATA_W-1:0]     mem_dout_q;

    // Outputs are loaded on the edge that enters the state they belong to.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= ST_IDLE;
            op_q       <= ALU_NOP;
            acc_mode_q <= 1'b0;
            mem_dout_q <= '0;
            busy       <= 1'b0;
            done       <= 1'b0;
            mem_addr   <= '0;
            mem_rw     <= 1'b1;
            alu_op     <= ALU_NOP;
            alu_a      <= '0;
            acc_we     <= 1'b0;
            flags_we   <= 1'b0;
            flags_out  <= '0;
        end else begin
            done     <= 1'b0;
            acc_we   <= 1'b0;
            flags_we <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (start && is_rmw_op(op)) begin
                        op_q       <= op;
                        acc_mode_q <= acc_mode;
                        busy       <= 1'b1;
                        if (acc_mode) begin
                            state  <= ST_MODIFY;
                            alu_op <= op;
                            alu_a  <= acc_in;
                        end else begin
                            state    <= ST_READ;
                            mem_addr <= addr;
                            mem_rw   <= 1'b1;
                        end
                    end
                end
                ST_READ: begin
                    state  <= ST_MODIFY;
                    alu_op <= op_q;
                    alu_a  <= mem_din;
`ifdef RMW_DUMMY_WRITE_EN
                    mem_rw     <= 1'b0;
                    mem_dout_q <= mem_din;
`else
                    mem_rw     <= 1'b1;
`endif
                end
                ST_MODIFY: begin
                    alu_op     <= ALU_NOP;
                    alu_a      <= '0;
                    flags_out  <= alu_flags;
                    flags_we   <= 1'b1;
                    done       <= 1'b1;
                    mem_dout_q <= '0;
                    if (acc_mode_q) begin
                        state  <= ST_WB_ACC;
                        acc_we <= 1'b1;
                    end else begin
                        state  <= ST_WRITE;
                        mem_rw <= 1'b0;
                    end
                end
                ST_WRITE, ST_WB_ACC: begin
                    state     <= ST_IDLE;
                    busy      <= 1'b0;
                    mem_addr  <= '0;
                    mem_rw    <= 1'b1;
                    flags_out <= '0;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    // The ALU result only becomes valid in the final cycle, so it is steered straight through.
    assign mem_dout = (state == ST_WRITE)  ? alu_result : mem_dout_q;
    assign acc_out  = (state == ST_WB_ACC) ? alu_result : DATA_W'(0);

endmodule

// File: tb/tb_rmw_sequencer.sv
// Directed bench for rmw_sequencer with a shift ALU, status register and 64 KiB memory model.
`timescale 1ns/1ps
module tb_rmw_sequencer;
    import rmw_sequencer_pkg::*;

`ifdef RMW_DUMMY_WRITE_EN
    localparam bit DUMMY = 1'b1;
`else
    localparam bit DUMMY = 1'b0;
`endif

    logic                clk = 1'b0;
    logic                rst = 1'b1;
    logic                start = 1'b0;
    logic [ALU_OP_W-1:0] op = ALU_NOP;
    logic                acc_mode = 1'b0;
    logic [ADDR_W-1:0]   addr = '0;
    logic [DATA_W-1:0]   acc_in = '0;
    logic                busy, done, mem_rw, acc_we, flags_we;
    logic [ADDR_W-1:0]   mem_addr;
    logic [DATA_W-1:0]   mem_dout, mem_din, alu_a, alu_result, acc_out;
    logic [ALU_OP_W-1:0] alu_op;
    logic [FLAGS_W-1:0]  alu_flags, flags_out;

    rmw_sequencer dut (
        .clk(clk), .rst(rst), .start(start), .op(op), .acc_mode(acc_mode),
        .addr(addr), .acc_in(acc_in), .busy(busy), .done(done),
        .mem_addr(mem_addr), .mem_rw(mem_rw), .mem_dout(mem_dout), .mem_din(mem_din),
        .alu_op(alu_op), .alu_a(alu_a), .alu_result(alu_result), .alu_flags(alu_flags),
        .acc_we(acc_we), .acc_out(acc_out), .flags_we(flags_we), .flags_out(flags_out)
    );

    always #5 clk = ~clk;

    // Status register: bench preset of C, otherwise C/Z/N from flags_we
    logic [FLAGS_W-1:0] p = '0;
    logic set_c = 1'b0, set_c_val = 1'b0;
    always @(posedge clk) begin
        if (set_c) p[FLAG_C] <= set_c_val;
        else if (flags_we) begin
            p[FLAG_C] <= flags_out[FLAG_C];
            p[FLAG_Z] <= flags_out[FLAG_Z];
            p[FLAG_N] <= flags_out[FLAG_N];
        end
    end

    // Shift ALU peer: combinational flags, registered result
    function automatic logic [8:0] shf(input logic [3:0] o, input logic [7:0] a, input logic c);
        case (o)
            ALU_ASL: return {a[7], a[6:0], 1'b0};
            ALU_LSR: return {a[0], 1'b0, a[7:1]};
            ALU_ROL: return {a[7], a[6:0], c};
            ALU_ROR: return {a[0], c, a[7:1]};
            default: return {c, a};
        endcase
    endfunction
    logic [8:0] alu_r;
    assign alu_r = shf(alu_op, alu_a, p[FLAG_C]);
    always_comb begin
        alu_flags         = '0;
        alu_flags[FLAG_C] = alu_r[8];
        alu_flags[FLAG_Z] = (alu_r[7:0] == 8'h00);
        alu_flags[FLAG_N] = alu_r[7];
    end
    always @(posedge clk) alu_result <= alu_r[7:0];

    // Memory model with bench preload port; logs every write
    logic [7:0]  mem [0:65535];
    logic        init_we = 1'b0;
    logic [15:0] init_addr = '0;
    logic [7:0]  init_data = '0;
    logic [7:0]  wr_log [0:255];
    int          wr_cnt = 0, done_cnt = 0, fwe_cnt = 0, awe_cnt = 0;
    assign mem_din = mem[mem_addr];
    always @(posedge clk) begin
        if (!mem_rw) begin
            mem[mem_addr]      <= mem_dout;
            wr_log[wr_cnt[7:0]] <= mem_dout;
            wr_cnt             <= wr_cnt + 1;
        end else if (init_we) mem[init_addr] <= init_data;
        if (done)     done_cnt <= done_cnt + 1;
        if (flags_we) fwe_cnt  <= fwe_cnt + 1;
        if (acc_we)   awe_cnt  <= awe_cnt + 1;
    end

    int tests = 0, fails = 0;
    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, " ctl"}, 32'({busy, done, mem_rw, acc_we, flags_we}), 32'(5'b00100));
        check({tag, " mem_addr"}, 32'(mem_addr), 32'h0);
        check({tag, " data"}, 32'({mem_dout, acc_out, alu_a}), 32'h0);
        check({tag, " alu_op/flags"}, 32'({alu_op, flags_out}), 32'({ALU_NOP, 7'h00}));
    endtask

    typedef struct {
        logic [3:0]  op;
        logic        acc;
        logic [15:0] addr;
        logic [7:0]  acc_in;
        logic [7:0]  mem_init;
        logic        c_in;
        logic [7:0]  exp_res;
        logic [2:0]  exp_nzc;
    } vec_t;
    vec_t vecs [8];

    task automatic run_vec(input int idx, input vec_t v);
        int cyc, dcyc, wr0, dn0, fw0, aw0, mod_cyc;
        logic mrw;
        logic [3:0] aop;
        logic [7:0] aout, res;
        string t;
        t = $sformatf("v%0d", idx);
        mod_cyc = v.acc ? 1 : 2;
        @(negedge clk);
        op = v.op; acc_mode = v.acc; addr = v.addr; acc_in = v.acc_in; start = 1'b1;
        init_we = 1'b1; init_addr = v.addr; init_data = v.mem_init;
        set_c = 1'b1; set_c_val = v.c_in;
        wr0 = wr_cnt; dn0 = done_cnt; fw0 = fwe_cnt; aw0 = awe_cnt;
        cyc = 0; dcyc = 0; mrw = 1'bx; aop = 'x; aout = 'x;
        while (dcyc == 0 && cyc < 8) begin
            @(posedge clk); #1;
            if (cyc == 0) begin start = 1'b0; init_we = 1'b0; set_c = 1'b0; end
            cyc++;
            if (cyc == mod_cyc) begin mrw = mem_rw; aop = alu_op; end
            if (done) begin dcyc = cyc; aout = acc_out; end
        end
        @(posedge clk); #1;
        res = v.acc ? aout : mem[v.addr];
        check({t, " done cycle"}, 32'(dcyc), v.acc ? 32'd2 : 32'd3);
        check({t, " result"}, 32'(res), 32'(v.exp_res));
        check({t, " NZC"}, 32'({p[FLAG_N], p[FLAG_Z], p[FLAG_C]}), 32'(v.exp_nzc));
        check({t, " modify alu_op"}, 32'(aop), 32'(v.op));
        check({t, " modify mem_rw"}, 32'(mrw), 32'(v.acc ? 1'b1 : !DUMMY));
        check({t, " writes"}, 32'(wr_cnt - wr0), v.acc ? 32'd0 : (DUMMY ? 32'd2 : 32'd1));
        check({t, " strobes"}, 32'({8'(done_cnt - dn0), 8'(fwe_cnt - fw0), 8'(awe_cnt - aw0)}),
              32'({8'd1, 8'd1, v.acc ? 8'd1 : 8'd0}));
        if (!v.acc)
            check({t, " first write"}, 32'(wr_log[wr0[7:0]]), 32'(DUMMY ? v.mem_init : v.exp_res));
        check({t, " idle after"}, 32'({busy, mem_rw}), 32'(2'b01));
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, tests=%0d", tests);
        $fatal(1, "watchdog");
    end

    initial begin
        int wr0, fw0, dn0;
        //         op       acc   addr      A      [addr] C  result  {N,Z,C}
        vecs[0] = '{ALU_ASL, 1'b0, 16'h0200, 8'h00, 8'h80, 1'b0, 8'h00, 3'b011};
        vecs[1] = '{ALU_ROL, 1'b1, 16'h0300, 8'h40, 8'h5A, 1'b1, 8'h81, 3'b100};
        vecs[2] = '{ALU_ROR, 1'b0, 16'h0010, 8'h00, 8'h01, 1'b0, 8'h00, 3'b011};
        vecs[3] = '{ALU_LSR, 1'b0, 16'h1234, 8'h00, 8'h03, 1'b0, 8'h01, 3'b001};
        vecs[4] = '{ALU_ASL, 1'b1, 16'h0300, 8'hC1, 8'h00, 1'b0, 8'h82, 3'b101};
        vecs[5] = '{ALU_LSR, 1'b1, 16'h0300, 8'h01, 8'h00, 1'b1, 8'h00, 3'b011};
        vecs[6] = '{ALU_ROL, 1'b0, 16'hFFFF, 8'h00, 8'h80, 1'b0, 8'h00, 3'b011};
        vecs[7] = '{ALU_ROR, 1'b1, 16'h0300, 8'h02, 8'h00, 1'b1, 8'h81, 3'b100};

        repeat (2) @(posedge clk);
        #1 check_reset_outputs("in reset");
        @(negedge clk) rst = 1'b0;
        @(posedge clk); #1 check_reset_outputs("after reset");

        for (int i = 0; i < 8; i++) run_vec(i, vecs[i]);

        // Illegal op in IDLE is ignored
        @(negedge clk);
        op = ALU_ADC; acc_mode = 1'b1; acc_in = 8'h11; start = 1'b1;
        dn0 = done_cnt;
        @(posedge clk); #1 start = 1'b0;
        check("illegal op busy", 32'(busy), 32'h0);

        // start while busy is ignored, exactly one done
        @(negedge clk);
        op = ALU_ROL; acc_mode = 1'b0; addr = 16'h0500; start = 1'b1;
        init_we = 1'b1; init_addr = 16'h0500; init_data = 8'h01; set_c = 1'b1; set_c_val = 1'b0;
        @(posedge clk); #1 start = 1'b0; init_we = 1'b0; set_c = 1'b0;
        @(posedge clk); #1 start = 1'b1; op = ALU_ASL; acc_mode = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        repeat (6) @(posedge clk);
        #1;
        check("filter done count", 32'(done_cnt - dn0), 32'd1);
        check("filter busy", 32'(busy), 32'h0);
        check("filter mem", 32'(mem[16'h0500]), 32'h02);

        // Reset asserted in MODIFY aborts with no write or flag update
        @(negedge clk);
        op = ALU_ASL; acc_mode = 1'b0; addr = 16'h0400; start = 1'b1;
        init_we = 1'b1; init_addr = 16'h0400; init_data = 8'h55;
        @(posedge clk); #1 start = 1'b0; init_we = 1'b0;
        wr0 = wr_cnt; fw0 = fwe_cnt; dn0 = done_cnt;
        @(posedge clk); #1;
        check("abort in modify", 32'({busy, alu_op}), 32'({1'b1, ALU_ASL}));
        #2 rst = 1'b1;
        #1 check_reset_outputs("mid-op reset");
        repeat (2) @(posedge clk);
        @(negedge clk) rst = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("abort writes", 32'(wr_cnt - wr0), 32'd0);
        check("abort strobes", 32'({8'(fwe_cnt - fw0), 8'(done_cnt - dn0)}), 32'h0);
        check("abort mem", 32'(mem[16'h0400]), 32'h55);
        check("abort busy", 32'(busy), 32'h0);

        // Back-to-back: second request held from the done cycle
        @(negedge clk);
        op = ALU_LSR; acc_mode = 1'b0; addr = 16'h0600; start = 1'b1;
        init_we = 1'b1; init_addr = 16'h0600; init_data = 8'h03; set_c = 1'b1; set_c_val = 1'b0;
        @(posedge clk); #1 start = 1'b0; init_we = 1'b0; set_c = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("b2b first done", 32'(done), 32'h1);
        start = 1'b1; op = ALU_ASL; acc_mode = 1'b1; acc_in = 8'h01;
        @(posedge clk); #1;
        check("b2b idle gap", 32'(busy), 32'h0);
        check("b2b lsr result", 32'({mem[16'h0600], p[FLAG_C]}), 32'({8'h01, 1'b1}));
        @(posedge clk); #1 start = 1'b0;
        check("b2b second accepted", 32'(busy), 32'h1);
        @(posedge clk); #1;
        check("b2b second done", 32'({done, acc_we, acc_out}), 32'({1'b1, 1'b1, 8'h02}));
        @(posedge clk); #1;
        check("b2b second flags", 32'({p[FLAG_N], p[FLAG_Z], p[FLAG_C]}), 32'(3'b000));

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/rmw_sequencer.md
# rmw_sequencer

Sequences the shift/rotate ALU for 6502 read-modify-write instructions (ASL, LSR, ROL, ROR) on either a memory operand or the accumulator. It sits between the instruction decoder, the memory bus, the accumulator and the status register. It fetches the operand, presents it to the ALU, captures the result and flags, and writes both back with exact 6502 bus-cycle ordering. One operation is in flight at a time; requests are accepted only when idle.

## Interface
Parameters:
- none

Ports:
- `clk` in 1: system clock; all state updates on the rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `start` in 1: request strobe, sampled only in IDLE.
- `op` in 4: ALU opcode from the shared ALU op codes; only ASL/LSR/ROL/ROR are legal.
- `acc_mode` in 1: 1 = operand is the accumulator; 0 = memory at `addr`.
- `addr` in 16: memory operand address, captured at accept.
- `acc_in` in 8: current accumulator value, captured at accept.
- `busy` out 1: high in every state except IDLE.
- `done` out 1: high during the final cycle of an operation.
- `mem_addr` out 16, `mem_rw` out 1 (1 = read), `mem_dout` out 8, `mem_din` in 8: memory bus.
- `alu_op` out 4, `alu_a` out 8: ALU controls.
- `alu_result` in 8: registered ALU output, valid one cycle after `alu_op`/`alu_a`.
- `alu_flags` in 7: combinational ALU flags.
- `acc_we` out 1, `acc_out` out 8: accumulator write-back.
- `flags_we` out 1, `flags_out` out 7: status update; the status register applies only bits C, Z and N.

## Operation
States: IDLE, READ, MODIFY, WRITE, WB_ACC.
- **IDLE**
  - `start`=1 with a legal `op`: latch `op`, `addr` and `acc_in`, then go to READ (`acc_mode`=0) or MODIFY (`acc_mode`=1).
  - Illegal `op`: the request is ignored and the state does not change.
  - `start` outside IDLE is ignored; it is not queued.
- **READ**: `mem_addr`=addr_q, `mem_rw`=1. Capture `mem_din` into operand_q at the end of the cycle. Go to MODIFY.
- **MODIFY**:
  - `alu_op`=op_q, `alu_a`=operand_q (memory) or acc_q (accumulator).
  - Capture `alu_flags` into flags_q at the end of the cycle.
  - Memory bus: see Configuration.
  - Next state: WRITE (memory) or WB_ACC (accumulator).
- **WRITE**: `mem_addr`=addr_q, `mem_rw`=0, `mem_dout`=`alu_result`. `done`=1, `flags_we`=1, `flags_out`=flags_q. Go to IDLE.
- **WB_ACC**: `acc_we`=1, `acc_out`=`alu_result`, `done`=1, `flags_we`=1. Go to IDLE.
- **Outside MODIFY**: `alu_op`=ALU_NOP, `alu_a`=0.
- **Carry for ROL/ROR**: the ALU reads carry directly from the status register. It is not touched here; the register cannot change mid-operation because `flags_we` fires only in the final cycle.

## Timing
- **Reset values**: state=IDLE, `busy`=0, `done`=0, `mem_rw`=1, `mem_addr`=0, `mem_dout`=0, `acc_we`=0, `acc_out`=0, `flags_we`=0, `flags_out`=0, `alu_op`=ALU_NOP, `alu_a`=0.
- **Latency**: accept edge at cycle 0.
  - Memory: READ in cycle 1, MODIFY in cycle 2, WRITE/`done` in cycle 3.
  - Accumulator: MODIFY in cycle 1, WB_ACC/`done` in cycle 2.
- **Back-to-back**: the earliest next accept is the edge at the end of the cycle after `done`, i.e. in IDLE.
- **Reset mid-operation**: return immediately to IDLE. No write or flag update from the aborted operation may occur after reset assertion.
- **Write strobes**: `done`, `acc_we` and `flags_we` are each high for exactly one cycle per accepted operation.

## Configuration
- **`RMW_DUMMY_WRITE_EN` defined**: MODIFY drives `mem_rw`=0 and `mem_dout`=operand_q to addr_q. This is the NMOS 6502 double write (old value, then new value).
- **Undefined**: MODIFY drives `mem_rw`=1 to addr_q, a dummy read.
- In both builds, accumulator mode never drives a write; `mem_rw`=1 throughout.
- State sequence and latency are identical in both builds.

## Structure
- **ALU op codes** (including a new ALU_NOP) belong in the shared ALU-ops include.
- **Flag bit positions** (C/Z/N) belong in the shared status-register include.
- **State encodings** are local `localparam`s.
- **Sub-modules**: none. The ALU is a peer instantiated by the parent, not inside this block.

## Test plan
Bench instantiates `alu` alongside the block, plus a 64 KiB memory model.
- **Memory ASL**: [0x0200]=0x80 -> bus writes 0x80 (macro on), then 0x00. C=1, Z=1, N=0; `done` in cycle 3.
- **Accumulator ROL**: A=0x40, C=1 -> `acc_out`=0x81, N=1, C=0, Z=0. `done` in cycle 2, no memory write.
- **Memory ROR**: [0x10]=0x01, C=0 -> written 0x00, C=1, Z=1. With the macro undefined, MODIFY shows `mem_rw`=1.
- **Request filtering**: `start` pulsed while `busy`, and `start` with an illegal op in IDLE -> both ignored; exactly one `done` for the legal request.
- **Reset mid-operation**: `rst` asserted in MODIFY -> immediate IDLE, all outputs at reset values, no WRITE, no `flags_we`.
- **Back-to-back**: LSR on 0x03 followed immediately by a second request -> 0x01 with C=1, then the second op is accepted the cycle after `done`.
